rv_pipe_ctrl: RTL and testbench
===============================

# rv_pipe_ctrl

Control and sequencing unit for the 3-stage RV32I core (Fetch, Execute, Writeback). It consumes the field outputs of the instruction decoder for the instruction in EX and sends datapath controls to the ALU, immediate mux, register file and CSR. It also produces the PC-redirect, flush and forwarding controls, and holds the EX→WB control pipeline register. A small FSM sequences boot and halts on an illegal instruction.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  fetch delivered a valid instruction into F/EX this cycle
- opcode  in  7, funct3  in  3, funct7  in  7, rd  in  5, rs1  in  5, rs2  in  5  decoder fields of EX instruction
- cmp_eq, cmp_lt, cmp_ltu  in  1 each  ALU compare flags for rs1 vs rs2
- fetch_en  out  1  advance PC / issue imem read
- pc_sel  out  2  00=PC+4, 01=PC+imm_b, 10=PC+imm_j, 11=(rs1+imm_i)&~1
- flush  out  1  load NOP into F/EX register next edge
- aluop  out  4  ALU operation (package enum)
- alusrc  out  1  0=rs2, 1=immediate
- imm_sel  out  2  00=I, 01=U, 10=B, 11=J
- csr_we  out  1  CSR write strobe (csrrw)
- regwrite_wb  out  1, rd_wb  out  5, wb_sel_wb  out  2  WB stage controls; wb_sel 00=ALU, 01=CSR, 10=U-imm, 11=PC+4
- fwd_a, fwd_b  out  1  forward WB result onto ALU operand A/B
- illegal  out  1  sticky illegal-instruction flag

## Operation
- ex_valid: internal flop, `ex_valid <= instr_valid & ~flush & (state==RUN | state==BOOT)`. All EX-side side effects (regwrite, csr_we, redirect) are gated by ex_valid.
- FSM states:
  - BOOT: entered on reset. fetch_en=1. Goes to RUN after one cycle.
  - RUN: normal operation. Goes to HALT on a valid illegal opcode or funct combination.
  - HALT: fetch_en=0 and all strobes 0. Leaves only on rst.
- Decode, combinational from EX fields:
  - 0110011 R: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU, plus funct7=0000001 MUL/MULH/MULHU; wb ALU.
  - 0010011 I-ALU: ALU ops with alusrc=1. SRAI is selected by funct7=0100000.
  - 0110111 LUI: wb U-imm, imm_sel=U.
  - 1101111 JAL: pc_sel=10, wb PC+4.
  - 1100111 JALR: pc_sel=11, wb PC+4.
  - 1100011 B: BEQ/BNE/BLT/BGE/BLTU/BGEU. taken = f(funct3, cmp_*). pc_sel=01 when taken. No regwrite.
- Any redirect (taken branch, JAL, JALR) asserts flush the same cycle. The younger instruction never writes.
- regwrite requires rd≠0. rd_wb=0 never forwards.
- fwd_a = regwrite_wb & rd_wb≠0 & rd_wb==rs1 & ex_valid. fwd_b uses rs2, and only for R-type and B-type.
- fetch_en=1 in RUN unless HALT. A cycle with instr_valid=0 becomes a bubble with no stall state.

## Timing
- All EX controls (aluop, alusrc, imm_sel, pc_sel, flush, csr_we, fwd_*) are combinational in the EX cycle.
- WB controls are registered and appear one cycle later.
- Redirect penalty: exactly 1 bubble.
- Reset values: state=BOOT, ex_valid=0, regwrite_wb=0, rd_wb=0, wb_sel_wb=00, illegal=0. Combinational outputs are 0 with ex_valid=0, except fetch_en=1 in BOOT.
- rst mid-instruction: all flops clear immediately, and any in-flight WB write is dropped.
- Illegal opcode and redirect in the same cycle cannot occur, because an illegal instruction never redirects.
- On HALT entry, the illegal instruction's WB is suppressed. The older WB still completes.

## Configuration
- `CTRL_CSR_EN` defined: opcode 1110011 funct3=001 (csrrw) asserts csr_we, wb_sel=01, regwrite if rd≠0.
- `CTRL_CSR_EN` undefined: opcode 1110011 is illegal and enters HALT. The csr_we port exists but is tied 0.

## Structure
- Package rv_ctrl_pkg holds:
  - opcode localparams
  - aluop_t enum (ADD=0, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL, MULH, MULHU)
  - pc_sel_t, wb_sel_t, imm_sel_t enums
  - ctrl_state_t {BOOT, RUN, HALT}
- Sub-module rv_branch_eval: funct3 + cmp_* → taken, combinational.

## Test plan
- Reset, then release: cycle 0 in BOOT with fetch_en=1. Cycle 1 in RUN. All WB outputs 0 throughout.
- add x3,x1,x2 then sub x4,x3,x1 back-to-back: second instruction fwd_a=1, fwd_b=0, aluop=SUB. WB cycle has regwrite_wb=1, rd_wb=4.
- beq with cmp_eq=1: pc_sel=01 and flush=1 in the same cycle. Next EX instruction (addi x5,x0,7) produces no regwrite.
- jal x1,+8: pc_sel=10, flush=1. Next cycle regwrite_wb=1, rd_wb=1, wb_sel_wb=11.
- addi x0,x0,1: regwrite_wb stays 0, and fwd_a=0 for a following instruction reading x0.
- Opcode 1110011 csrrw: with CTRL_CSR_EN, csr_we=1 for one cycle. Without it, illegal=1, state=HALT, fetch_en=0 until rst.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I 3-stage core control unit.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    // Major opcodes handled by the control unit
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // funct7 variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULH  = 4'd11,
        ALU_MULHU = 4'd12
    } aluop_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_CSR  = 2'b01,
        WB_UIMM = 2'b10,
        WB_PC4  = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_U = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_sel_t;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } ctrl_state_t;

    // Base integer ALU op from funct3; alt selects SUB (f3=000) / SRA (f3=101).
    function automatic aluop_t base_aluop(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_aluop = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_aluop = ALU_SLL;
            3'b010:  base_aluop = ALU_SLT;
            3'b011:  base_aluop = ALU_SLTU;
            3'b100:  base_aluop = ALU_XOR;
            3'b101:  base_aluop = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_aluop = ALU_OR;
            default: base_aluop = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_branch_eval.sv
// Branch condition evaluator: funct3 + ALU compare flags -> taken.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct3_i, cmp_eq_i/cmp_lt_i/cmp_ltu_i in; taken_o, valid_o (funct3 is a real branch) out.
module rv_branch_eval (
    input  logic [2:0] funct3_i,
    input  logic       cmp_eq_i,
    input  logic       cmp_lt_i,
    input  logic       cmp_ltu_i,
    output logic       taken_o,
    output logic       valid_o
);

    always_comb begin
        taken_o = 1'b0;
        valid_o = 1'b1;
        case (funct3_i)
            3'b000:  taken_o = cmp_eq_i;    // BEQ
            3'b001:  taken_o = ~cmp_eq_i;   // BNE
            3'b100:  taken_o = cmp_lt_i;    // BLT
            3'b101:  taken_o = ~cmp_lt_i;   // BGE
            3'b110:  taken_o = cmp_ltu_i;   // BLTU
            3'b111:  taken_o = ~cmp_ltu_i;  // BGEU
            default: valid_o = 1'b0;        // 010/011 are not branches
        endcase
    end

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Control/sequencing for the 3-stage RV32I core: EX decode, redirect/flush, forwarding, EX->WB control register, boot/halt FSM.
// Latency: EX controls combinational in the EX cycle; WB controls registered, one cycle later.
// Backpressure: none; instr_valid=0 becomes a bubble, HALT stops fetch until rst. Optional csrrw decode under `CTRL_CSR_EN.
// Ports: clk, rst (async, active-high); instr_valid + decoder fields (opcode, funct3, funct7, rd, rs1, rs2) + cmp_eq/lt/ltu in;
//        fetch_en, pc_sel, flush, aluop, alusrc, imm_sel, csr_we, regwrite_wb, rd_wb, wb_sel_wb, fwd_a, fwd_b, illegal out.
module rv_pipe_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    input  logic       cmp_ltu,
    output logic       fetch_en,
    output logic [1:0] pc_sel,
    output logic       flush,
    output logic [3:0] aluop,
    output logic       alusrc,
    output logic [1:0] imm_sel,
    output logic       csr_we,
    output logic       regwrite_wb,
    output logic [4:0] rd_wb,
    output logic [1:0] wb_sel_wb,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       illegal
);

    ctrl_state_t state_q, state_d;
    logic        ex_valid_q, ex_valid_d;
    logic        regwrite_wb_q, regwrite_wb_d;
    logic [4:0]  rd_wb_q, rd_wb_d;
    wb_sel_t     wb_sel_wb_q, wb_sel_wb_d;
    logic        illegal_q, illegal_d;

    // Raw decode of the EX fields
    logic     dec_legal, dec_src, dec_wr, dec_jump, dec_is_b, dec_csr, dec_useb;
    aluop_t   dec_alu;
    imm_sel_t dec_imm;
    wb_sel_t  dec_wb;
    pc_sel_t  dec_pc;

    logic br_taken, br_valid;
    logic ex_act, issue, redirect;

    rv_branch_eval u_branch_eval (
        .funct3_i  (funct3),
        .cmp_eq_i  (cmp_eq),
        .cmp_lt_i  (cmp_lt),
        .cmp_ltu_i (cmp_ltu),
        .taken_o   (br_taken),
        .valid_o   (br_valid)
    );

    always_comb begin
        dec_legal = 1'b0;
        dec_src   = 1'b0;
        dec_wr    = 1'b0;
        dec_jump  = 1'b0;
        dec_is_b  = 1'b0;
        dec_csr   = 1'b0;
        dec_useb  = 1'b0;
        dec_alu   = ALU_ADD;
        dec_imm   = IMM_I;
        dec_wb    = WB_ALU;
        dec_pc    = PC_PLUS4;
        case (opcode)
            OP_R: begin
                dec_wr   = 1'b1;
                dec_useb = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        dec_legal = 1'b1;
                        dec_alu   = base_aluop(funct3, 1'b0);
                    end
                    F7_ALT: begin
                        // only SUB and SRA have an alternate encoding
                        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                        dec_alu   = base_aluop(funct3, 1'b1);
                    end
                    F7_MULDIV: begin
                        case (funct3)
                            3'b000:  begin dec_legal = 1'b1; dec_alu = ALU_MUL;   end
                            3'b001:  begin dec_legal = 1'b1; dec_alu = ALU_MULH;  end
                            3'b011:  begin dec_legal = 1'b1; dec_alu = ALU_MULHU; end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            OP_IMM: begin
                dec_wr  = 1'b1;
                dec_src = 1'b1;
                // funct7 is immediate data except for the shift-immediate forms
                if (funct3 == 3'b001) begin
                    dec_legal = (funct7 == F7_BASE);
                    dec_alu   = ALU_SLL;
                end else if (funct3 == 3'b101) begin
                    dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    dec_alu   = base_aluop(funct3, funct7 == F7_ALT);
                end else begin
                    dec_legal = 1'b1;
                    dec_alu   = base_aluop(funct3, 1'b0);
                end
            end
            OP_LUI: begin
                dec_legal = 1'b1;
                dec_wr    = 1'b1;
                dec_src   = 1'b1;
                dec_imm   = IMM_U;
                dec_wb    = WB_UIMM;
            end
            OP_JAL: begin
                dec_legal = 1'b1;
                dec_wr    = 1'b1;
                dec_jump  = 1'b1;
                dec_imm   = IMM_J;
                dec_wb    = WB_PC4;
                dec_pc    = PC_JAL;
            end
            OP_JALR: begin
                dec_legal = (funct3 == 3'b000);
                dec_wr    = 1'b1;
                dec_jump  = 1'b1;
                dec_src   = 1'b1;
                dec_imm   = IMM_I;
                dec_wb    = WB_PC4;
                dec_pc    = PC_JALR;
            end
            OP_BRANCH: begin
                dec_legal = br_valid;
                dec_is_b  = 1'b1;
                dec_useb  = 1'b1;
                dec_imm   = IMM_B;
                dec_pc    = PC_BRANCH;
            end
`ifdef CTRL_CSR_EN
            OP_SYSTEM: begin
                dec_legal = (funct3 == 3'b001);  // csrrw only
                dec_csr   = 1'b1;
                dec_wr    = 1'b1;
                dec_wb    = WB_CSR;
            end
`endif
            default: ;
        endcase
    end

    // HALT gates EX even if an instruction was latched on the halting edge
    assign ex_act   = ex_valid_q & (state_q != HALT);
    assign issue    = ex_act & dec_legal;
    assign redirect = issue & (dec_jump | (dec_is_b & br_taken));

    assign fetch_en = (state_q != HALT);
    assign flush    = redirect;
    assign pc_sel   = redirect ? dec_pc : PC_PLUS4;
    assign aluop    = issue ? dec_alu : ALU_ADD;
    assign alusrc   = issue & dec_src;
    assign imm_sel  = issue ? dec_imm : IMM_I;
    // dec_csr can only be set when the CSR decode is compiled in
    assign csr_we   = issue & dec_csr;

    assign fwd_a = ex_act & regwrite_wb_q & (rd_wb_q != 5'd0) & (rd_wb_q == rs1);
    assign fwd_b = ex_act & regwrite_wb_q & (rd_wb_q != 5'd0) & (rd_wb_q == rs2) & dec_useb;

    assign regwrite_wb = regwrite_wb_q;
    assign rd_wb       = rd_wb_q;
    assign wb_sel_wb   = wb_sel_wb_q;
    assign illegal     = illegal_q;

    // Next state / WB pipeline; WB fields are zeroed when nothing is written
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        ex_valid_d    = instr_valid & ~redirect & ((state_q == RUN) | (state_q == BOOT));
        regwrite_wb_d = issue & dec_wr & (rd != 5'd0);
        rd_wb_d       = regwrite_wb_d ? rd : 5'd0;
        wb_sel_wb_d   = regwrite_wb_d ? dec_wb : WB_ALU;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (ex_act & ~dec_legal) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            ex_valid_q    <= 1'b0;
            regwrite_wb_q <= 1'b0;
            rd_wb_q       <= 5'd0;
            wb_sel_wb_q   <= WB_ALU;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ex_valid_q    <= ex_valid_d;
            regwrite_wb_q <= regwrite_wb_d;
            rd_wb_q       <= rd_wb_d;
            wb_sel_wb_q   <= wb_sel_wb_d;
            illegal_q     <= illegal_d;
        end
    end

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Bench for rv_pipe_ctrl: directed steps plus random instruction streams against a
// mnemonic-table reference model of the pipeline (EX valid, WB register, boot/halt).
module tb_rv_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [6:0] opcode = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
    logic       cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
    logic       fetch_en, flush, alusrc, csr_we, regwrite_wb, fwd_a, fwd_b, illegal;
    logic [1:0] pc_sel, imm_sel, wb_sel_wb;
    logic [3:0] aluop;
    logic [4:0] rd_wb;

    always #5 clk = ~clk;

    rv_pipe_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
        .fetch_en(fetch_en), .pc_sel(pc_sel), .flush(flush), .aluop(aluop),
        .alusrc(alusrc), .imm_sel(imm_sel), .csr_we(csr_we),
        .regwrite_wb(regwrite_wb), .rd_wb(rd_wb), .wb_sel_wb(wb_sel_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
    );

    int total = 0;
    int bad   = 0;

    // Instruction table entry: encoding plus the controls the instruction must produce.
    // jmp: 0 none, 2 JAL, 3 JALR.  br: -1 none, 0..5 = EQ,NE,LT,GE,LTU,GEU.
    typedef struct {
        bit [6:0] op; bit [2:0] f3; bit [6:0] f7;
        int alu; bit src; int imm; int wb; bit wr;
        int jmp; int br; bit useb; bit legal; bit csr;
    } ent_t;

    // R-type mnemonics 0..12 in aluop order: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU MUL MULH MULHU
    localparam bit [2:0] RF3 [13] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1, 3'd3};
    localparam bit [6:0] RF7 [13] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h01, 7'h01, 7'h01};
    // Branch mnemonics 21..26: BEQ BNE BLT BGE BLTU BGEU
    localparam bit [2:0] BF3 [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    function automatic ent_t mk(bit [6:0] op, bit [2:0] f3, bit [6:0] f7, int alu, bit src, int imm,
                                int wb, bit wr, int jmp, int br, bit useb, bit legal, bit csr);
        ent_t e;
        e.op = op; e.f3 = f3; e.f7 = f7; e.alu = alu; e.src = src; e.imm = imm; e.wb = wb;
        e.wr = wr; e.jmp = jmp; e.br = br; e.useb = useb; e.legal = legal; e.csr = csr;
        return e;
    endfunction

    function automatic ent_t ent(int k);
        if (k >= 0 && k <= 12) return mk(7'h33, RF3[k], RF7[k], k, 0, 0, 0, 1, 0, -1, 1, 1, 0);
        if (k >= 21 && k <= 26) return mk(7'h63, BF3[k-21], 7'h0b, 0, 0, 2, 0, 0, 0, k-21, 1, 1, 0);
        case (k)
            13: return mk(7'h13, 3'd0, 7'h55, 0, 1, 0, 0, 1, 0, -1, 0, 1, 0);  // ADDI
            14: return mk(7'h13, 3'd3, 7'h7f, 9, 1, 0, 0, 1, 0, -1, 0, 1, 0);  // SLTIU
            15: return mk(7'h13, 3'd5, 7'h20, 7, 1, 0, 0, 1, 0, -1, 0, 1, 0);  // SRAI
            16: return mk(7'h13, 3'd5, 7'h00, 6, 1, 0, 0, 1, 0, -1, 0, 1, 0);  // SRLI
            17: return mk(7'h13, 3'd7, 7'h20, 2, 1, 0, 0, 1, 0, -1, 0, 1, 0);  // ANDI
            18: return mk(7'h37, 3'd5, 7'h13, 0, 1, 1, 2, 1, 0, -1, 0, 1, 0);  // LUI
            19: return mk(7'h6f, 3'd2, 7'h40, 0, 0, 3, 3, 1, 2, -1, 0, 1, 0);  // JAL
            20: return mk(7'h67, 3'd0, 7'h11, 0, 1, 0, 3, 1, 3, -1, 0, 1, 0);  // JALR
`ifdef CTRL_CSR_EN
            27: return mk(7'h73, 3'd1, 7'h00, 0, 0, 0, 1, 1, 0, -1, 0, 1, 1);  // CSRRW
`else
            27: return mk(7'h73, 3'd1, 7'h00, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0);  // CSRRW (absent)
`endif
            28: return mk(7'h03, 3'd2, 7'h00, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0);  // LW (unsupported)
            29: return mk(7'h33, 3'd7, 7'h20, 0, 0, 0, 0, 0, 0, -1, 1, 0, 0);  // bad R funct combo
            default: return mk(7'h00, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0);
        endcase
    endfunction

    // Reference model state: 0=boot 1=run 2=halt
    int       m_state;
    bit       m_exv, m_wb_wr, m_ill;
    bit [4:0] m_wb_rd;
    int       m_wb_sel;

    task automatic model_reset();
        m_state = 0; m_exv = 0; m_wb_wr = 0; m_ill = 0; m_wb_rd = 0; m_wb_sel = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive EX fields (k<0 = random junk while EX is empty), check at
    // mid-cycle against the model, advance the model, return just after the next edge.
    task automatic step(input bit iv, input int k, input bit [4:0] a_rd, input bit [4:0] a_rs1,
                        input bit [4:0] a_rs2, input bit [2:0] cmp);
        int kk; ent_t e; bit act, iss, tk, wr; int pcs;
        kk = (k < 0 && m_exv) ? 13 : k;
        e = ent(kk);
        instr_valid = iv;
        if (kk < 0) begin
            opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        end else begin
            opcode = e.op; funct3 = e.f3; funct7 = e.f7;
        end
        rd = a_rd; rs1 = a_rs1; rs2 = a_rs2;
        {cmp_ltu, cmp_lt, cmp_eq} = cmp;
        #4;
        act = m_exv && (m_state != 2);
        iss = act && e.legal;
        tk  = 0;
        if (iss && e.jmp != 0) tk = 1;
        if (iss && e.br >= 0) begin
            case (e.br)
                0: tk = cmp[0];
                1: tk = !cmp[0];
                2: tk = cmp[1];
                3: tk = !cmp[1];
                4: tk = cmp[2];
                default: tk = !cmp[2];
            endcase
        end
        pcs = !tk ? 0 : ((e.br >= 0) ? 1 : e.jmp);
        chk("fetch_en", 8'(fetch_en), 8'(m_state != 2));
        chk("pc_sel",   8'(pc_sel),   8'(pcs));
        chk("flush",    8'(flush),    8'(tk));
        chk("aluop",    8'(aluop),    8'(iss ? e.alu : 0));
        chk("alusrc",   8'(alusrc),   8'(iss && e.src));
        chk("imm_sel",  8'(imm_sel),  8'(iss ? e.imm : 0));
        chk("csr_we",   8'(csr_we),   8'(iss && e.csr));
        chk("regwrite_wb", 8'(regwrite_wb), 8'(m_wb_wr));
        chk("rd_wb",    8'(rd_wb),    8'(m_wb_rd));
        chk("wb_sel_wb", 8'(wb_sel_wb), 8'(m_wb_sel));
        chk("fwd_a", 8'(fwd_a), 8'(act && m_wb_wr && m_wb_rd != 0 && m_wb_rd == a_rs1));
        chk("fwd_b", 8'(fwd_b), 8'(act && m_wb_wr && m_wb_rd != 0 && m_wb_rd == a_rs2 && e.useb));
        chk("illegal",  8'(illegal),  8'(m_ill));
        // advance model
        wr = iss && e.wr && (a_rd != 0);
        m_exv    = iv && !tk && (m_state != 2);
        m_wb_wr  = wr;
        m_wb_rd  = wr ? a_rd : 5'd0;
        m_wb_sel = wr ? e.wb : 0;
        if (m_state == 0) m_state = 1;
        else if (m_state == 1 && act && !e.legal) begin
            m_state = 2;
            m_ill   = 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset just after an edge; every flop must clear immediately.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        chk("rst_regwrite_wb", 8'(regwrite_wb), 8'd0);
        chk("rst_rd_wb",       8'(rd_wb),       8'd0);
        chk("rst_wb_sel_wb",   8'(wb_sel_wb),   8'd0);
        chk("rst_illegal",     8'(illegal),     8'd0);
        chk("rst_fetch_en",    8'(fetch_en),    8'd1);
        chk("rst_flush",       8'(flush),       8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int illk[3];
        illk = '{29, 28, 27};
        @(posedge clk);
        #1;
        do_reset();

        // boot cycle, then add/sub forwarding
        step(1, 13, 5'd6, 5'd0, 5'd0, 3'b000);  // BOOT: EX empty
        step(1, 0,  5'd3, 5'd1, 5'd2, 3'b000);  // add x3,x1,x2
        step(1, 1,  5'd4, 5'd3, 5'd1, 3'b000);  // sub x4,x3,x1 -> fwd_a
        // taken beq then flushed addi x5,x0,7
        step(1, 21, 5'd0, 5'd1, 5'd2, 3'b001);
        step(1, 13, 5'd5, 5'd0, 5'd0, 3'b000);
        // jal x1 then the flushed slot shows WB of x1 with PC+4
        step(1, 19, 5'd1, 5'd0, 5'd0, 3'b000);
        step(1, 13, 5'd7, 5'd1, 5'd0, 3'b000);
        // addi x0,x0,1 then a reader of x0
        step(1, 13, 5'd0, 5'd0, 5'd0, 3'b000);
        step(1, 0,  5'd2, 5'd0, 5'd0, 3'b000);
        // bubble, then an empty EX carrying garbage fields
        step(0, 0,  5'd7, 5'd2, 5'd2, 3'b000);
        step(1, -1, 5'd9, 5'd1, 5'd1, 3'b111);

        // random legal instruction stream with bubbles
        for (int i = 0; i < 400; i++) begin
            int k;
            k = m_exv ? int'($urandom_range(0, 26))
                      : ($urandom_range(0, 1) != 0 ? -1 : int'($urandom_range(0, 26)));
            step($urandom_range(0, 3) != 0, k, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 3'($urandom));
        end

        // reset while a WB write is in flight
        step(1, 0, 5'd5, 5'd1, 5'd2, 3'b000);
        step(1, 0, 5'd6, 5'd1, 5'd2, 3'b000);
        do_reset();
        step(1, 13, 5'd6, 5'd0, 5'd0, 3'b000);
        step(1, 13, 5'd6, 5'd0, 5'd0, 3'b000);

        // illegal encodings (and csrrw, which is legal only with the CSR option)
        foreach (illk[j]) begin
            do_reset();
            step(1, 13, 5'd6, 5'd0, 5'd0, 3'b000);  // BOOT
            step(1, 13, 5'd6, 5'd0, 5'd0, 3'b000);  // addi x6: older WB must complete
            step(1, illk[j], 5'd9, 5'd0, 5'd0, 3'b000);
            for (int c = 0; c < 4; c++)
                step(1, 0, 5'd8, 5'd9, 5'd9, 3'b000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
